id_ex_stage: RTL

//  ID/EX pipeline register plus EX-side operand selection feeding the ALU.

---
 rtl/id_ex_stage_pkg.sv | 18 +
 rtl/id_ex_stage_fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: ALU opcodes and forwarding-source encoding shared by the ID/EX stage
package id_ex_stage_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_SLT = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  typedef enum logic [1:0] {
    FWD_NONE  = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: picks the freshest value of one source register from EX/MEM, MEM/WB or the regfile
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic [XLEN-1:0]       rs_data_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_we_i,
  input  logic [XLEN-1:0]       exmem_res_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_we_i,
  input  logic [XLEN-1:0]       memwb_res_i,
  output logic [XLEN-1:0]       data_o
);
  fwd_sel_e w_sel;
  // EX/MEM is checked first so the younger result wins; x0 never matches
  always_comb begin
    w_sel = (exmem_we_i && exmem_rd_i != '0 && exmem_rd_i == rs_i) ? FWD_EXMEM :
            (memwb_we_i && memwb_rd_i != '0 && memwb_rd_i == rs_i) ? FWD_MEMWB : FWD_NONE;
    data_o = w_sel == FWD_EXMEM ? exmem_res_i :
             w_sel == FWD_MEMWB ? memwb_res_i : rs_data_i;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side forwarding, operand select and load-use stall
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_i,
  input  logic                  id_use_rs1_i,
  input  logic                  id_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [XLEN-1:0]       id_rs1_data_i,
  input  logic [XLEN-1:0]       id_rs2_data_i,
  input  logic [XLEN-1:0]       id_imm_i,
  input  logic [XLEN-1:0]       id_pc_i,
  input  logic [3:0]            id_alu_op_i,
  input  logic                  id_a_sel_pc_i,
  input  logic                  id_b_sel_imm_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_reg_write_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_we_i,
  input  logic [XLEN-1:0]       exmem_res_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_we_i,
  input  logic [XLEN-1:0]       memwb_res_i,
  input  logic                  hold_i,
  input  logic                  flush_i,
  output logic                  stall_o,
  output logic [XLEN-1:0]       alu_a_o,
  output logic [XLEN-1:0]       alu_b_o,
  output logic [3:0]            alu_op_o,
  output logic [XLEN-1:0]       store_data_o,
  output logic                  ex_valid_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_reg_write_o,
  output logic [XLEN-1:0]       ex_pc_o
);
  logic                  r_valid, r_mem_read, r_mem_write, r_reg_write, r_a_sel_pc, r_b_sel_imm;
  logic [REG_ADDR_W-1:0] r_rd, r_rs1, r_rs2;
  logic [XLEN-1:0]       r_rs1_data, r_rs2_data, r_imm, r_pc;
  logic [3:0]            r_alu_op;
  logic [XLEN-1:0]       w_fwd_rs1, w_fwd_rs2;
  logic                  w_bubble;
  always_comb begin
    stall_o = r_valid && r_mem_read && r_rd != '0 && id_valid_i && !flush_i &&
              ((id_use_rs1_i && id_rs1_i == r_rd) || (id_use_rs2_i && id_rs2_i == r_rd));
    w_bubble = flush_i || stall_o || !id_valid_i;
  end
  // Data registers follow ID even on a bubble; only control is cleared
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_alu_op    <= ALU_ADD;
      r_a_sel_pc  <= 1'b0;
      r_b_sel_imm <= 1'b0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
    end else if (!hold_i) begin
      r_valid     <= !w_bubble;
      r_mem_read  <= !w_bubble && id_mem_read_i;
      r_mem_write <= !w_bubble && id_mem_write_i;
      r_reg_write <= !w_bubble && id_reg_write_i;
      r_rd        <= w_bubble ? '0 : id_rd_i;
      r_alu_op    <= w_bubble ? ALU_ADD : id_alu_op_i;
      r_a_sel_pc  <= id_a_sel_pc_i;
      r_b_sel_imm <= id_b_sel_imm_i;
      r_rs1       <= id_rs1_i;
      r_rs2       <= id_rs2_i;
      r_rs1_data  <= id_rs1_data_i;
      r_rs2_data  <= id_rs2_data_i;
      r_imm       <= id_imm_i;
      r_pc        <= id_pc_i;
    end
  end
  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_i(r_rs1), .rs_data_i(r_rs1_data),
    .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_we_i), .exmem_res_i(exmem_res_i),
    .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_we_i), .memwb_res_i(memwb_res_i),
    .data_o(w_fwd_rs1)
  );
  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_i(r_rs2), .rs_data_i(r_rs2_data),
    .exmem_rd_i(exmem_rd_i), .exmem_we_i(exmem_we_i), .exmem_res_i(exmem_res_i),
    .memwb_rd_i(memwb_rd_i), .memwb_we_i(memwb_we_i), .memwb_res_i(memwb_res_i),
    .data_o(w_fwd_rs2)
  );
  assign alu_a_o        = r_a_sel_pc ? r_pc : w_fwd_rs1;
  assign alu_b_o        = r_b_sel_imm ? r_imm : w_fwd_rs2;
  assign store_data_o   = w_fwd_rs2;
  assign alu_op_o       = r_alu_op;
  assign ex_valid_o     = r_valid;
  assign ex_rd_o        = r_rd;
  assign ex_mem_read_o  = r_mem_read;
  assign ex_mem_write_o = r_mem_write;
  assign ex_reg_write_o = r_reg_write;
  assign ex_pc_o        = r_pc;
endmodule
